// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - RV32M function codes, FSM states and operand helpers
package mul_div_unit_pkg;

  localparam int MD_XLEN = 32;
  localparam int MD_FN_W = 3;

  typedef enum logic [MD_FN_W-1:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_fn_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_div(md_fn_e fn);
    return fn[2];
  endfunction

  // MUL needs no sign handling: the low half of the product is sign-agnostic.
  function automatic logic signed_a(md_fn_e fn);
    return fn inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic signed_b(md_fn_e fn);
    return fn inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - execute-stage request/result bundle of the mul/div unit
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = MD_XLEN
);
  logic               start;
  logic [MD_FN_W-1:0] md_fn;
  logic [XLEN-1:0]    rs1_data;
  logic [XLEN-1:0]    rs2_data;
  logic               kill;
  logic               busy;
  logic               done;
  logic [XLEN-1:0]    out;

  modport master (
    output start, md_fn, rs1_data, rs2_data, kill,
    input  busy, done, out
  );

  modport slave (
    input  start, md_fn, rs1_data, rs2_data, kill,
    output busy, done, out
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide, shift-add multiply and restoring divide
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave md
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  XMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e          state_q, state_d;
  md_fn_e             fn_q;
  logic [2*XLEN-1:0]  acc_q;
  logic [XLEN-1:0]    opnd_q;
  logic               neg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [XLEN-1:0]    out_q;
  logic               busy_c, done_c;

  md_fn_e             fn_in;
  logic               a_neg, b_neg, div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]    abs_a, abs_b, special_res;

  assign fn_in    = md_fn_e'(md.md_fn);
  assign a_neg    = signed_a(fn_in) & md.rs1_data[XLEN-1];
  assign b_neg    = signed_b(fn_in) & md.rs2_data[XLEN-1];
  assign abs_a    = a_neg ? -md.rs1_data : md.rs1_data;
  assign abs_b    = b_neg ? -md.rs2_data : md.rs2_data;
  assign div_zero = (md.rs2_data == '0);
  assign div_ovf  = (fn_in inside {MD_DIV, MD_REM}) && (md.rs1_data == XMIN) && (md.rs2_data == '1);
  assign special  = is_div(fn_in) && (div_zero || div_ovf);
  assign accept   = (state_q == ST_IDLE) && md.start && !md.kill;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = (fn_in inside {MD_DIV, MD_DIVU}) ? '1 : md.rs1_data;
    end else if (fn_in == MD_DIV) begin
      special_res = XMIN;
    end
  end

  // One iteration of each algorithm; acc_q holds {partial, multiplier} or {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
  assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   fix_res;

  assign prod_fixed = neg_q ? -acc_q : acc_q;

  always_comb begin
    fix_res = '0;
    unique case (fn_q)
      MD_MUL:                       fix_res = prod_fixed[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fixed[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      MD_REM, MD_REMU:              fix_res = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      default:                      fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_c  = (state_q != ST_IDLE);
    done_c  = (state_q == ST_DONE);
    unique case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (md.kill) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fn_q   <= MD_MUL;
      acc_q  <= '0;
      opnd_q <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else if (!md.kill) begin
      unique case (state_q)
        ST_IDLE: if (accept) begin
          fn_q  <= fn_in;
          cnt_q <= '0;
          if (is_div(fn_in)) begin
            acc_q  <= {{XLEN{1'b0}}, abs_a};
            opnd_q <= abs_b;
            neg_q  <= (fn_in == MD_REM) ? a_neg : (a_neg ^ b_neg);
          end else begin
            acc_q  <= {{XLEN{1'b0}}, abs_b};
            opnd_q <= abs_a;
            neg_q  <= a_neg ^ b_neg;
          end
          if (special) out_q <= special_res;
        end
        ST_CALC: begin
          acc_q <= is_div(fn_q) ? div_next : mul_next;
          cnt_q <= cnt_q + 1'b1;
        end
        ST_FIX:  out_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign md.busy = busy_c;
  assign md.done = done_c;
  assign md.out  = out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  logic [31:0] last_out = 32'h0;

  mul_div_unit_if md_if ();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .md  (md_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] val;
    int          cyc;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;

  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          p;
    longint unsigned pu;
    case (fn)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; pu = ua / ub; return pu[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; pu = ua % ub; return pu[31:0]; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    if (fn < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (fn == 3'd4 || fn == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request, in value and arrival cycle.
  always @(negedge clk) begin
    if (!rst && md_if.done === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_done: out %h with no outstanding request", md_if.out);
      end else begin
        m_e = exp_q.pop_front();
        if (md_if.out !== m_e.val) begin
          mismatched++;
          $display("FAIL result fn=%0d a=%h b=%h: got %h expected %h", m_e.fn, m_e.a, m_e.b, md_if.out, m_e.val);
        end
        compared++;
        if (cyc != m_e.cyc) begin
          mismatched++;
          $display("FAIL latency fn=%0d: done at cycle %0d expected %0d", m_e.fn, cyc, m_e.cyc);
        end
      end
    end
  end

  task automatic push_exp(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] val, input int done_cyc);
    exp_t e;
    e.val = val; e.cyc = done_cyc; e.fn = fn; e.a = a; e.b = b;
    exp_q.push_back(e);
    last_out = val;
  endtask

  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] val);
    @(negedge clk);
    md_if.md_fn = fn; md_if.rs1_data = a; md_if.rs2_data = b; md_if.start = 1'b1;
    if (push) push_exp(fn, a, b, val, cyc + (is_special(fn, a, b) ? 1 : 34));
    @(negedge clk);
    md_if.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    bit busy_ok = 1'b1;
    while (md_if.done !== 1'b1 && n < 60) begin
      if (md_if.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'h0, md_if.done}, 32'h1);
    check("busy_during_op", {31'h0, busy_ok & md_if.busy}, 32'h1);
    @(negedge clk);
    check("busy_after_done", {31'h0, md_if.busy}, 32'h0);
    check("done_single_pulse", {31'h0, md_if.done}, 32'h0);
  endtask

  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b, input logic [31:0] val);
    issue(fn, a, b, 1'b1, val);
    wait_done();
  endtask

  logic [2:0]  d_fn [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a  [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b  [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_r  [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};

  initial begin
    md_if.start = 1'b0; md_if.kill = 1'b0; md_if.md_fn = 3'd0;
    md_if.rs1_data = 32'h0; md_if.rs2_data = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'h0, md_if.busy}, 32'h0);
    check("reset_done", {31'h0, md_if.done}, 32'h0);
    check("reset_out", md_if.out, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_op(d_fn[i], d_a[i], d_b[i], d_r[i]);

    // Kill during CALC: no done, result register untouched.
    issue(3'd0, 32'd1234, 32'd5678, 1'b0, 32'h0);
    repeat (8) @(negedge clk);
    md_if.kill = 1'b1;
    @(negedge clk);
    md_if.kill = 1'b0;
    check("kill_busy", {31'h0, md_if.busy}, 32'h0);
    check("kill_out_held", md_if.out, last_out);
    repeat (40) @(negedge clk);
    check("kill_no_done_out", md_if.out, last_out);

    // Kill wins over start in IDLE.
    @(negedge clk);
    md_if.md_fn = 3'd5; md_if.rs1_data = 32'd9; md_if.rs2_data = 32'd0;
    md_if.start = 1'b1; md_if.kill = 1'b1;
    @(negedge clk);
    md_if.start = 1'b0; md_if.kill = 1'b0;
    check("kill_over_start_busy", {31'h0, md_if.busy}, 32'h0);
    repeat (3) @(negedge clk);

    // A second start while busy is ignored.
    issue(3'd5, 32'd1000, 32'd7, 1'b1, 32'd142);
    repeat (3) @(negedge clk);
    md_if.md_fn = 3'd0; md_if.rs1_data = 32'd3; md_if.rs2_data = 32'd3; md_if.start = 1'b1;
    @(negedge clk);
    md_if.start = 1'b0;
    wait_done();

    // Start held through DONE: accepted only in the following IDLE cycle (35-cycle cadence).
    issue(3'd1, 32'h12345678, 32'h9ABCDEF0, 1'b1, model(3'd1, 32'h12345678, 32'h9ABCDEF0));
    md_if.md_fn = 3'd7; md_if.rs1_data = 32'd1001; md_if.rs2_data = 32'd10; md_if.start = 1'b1;
    begin
      int n = 0;
      while (md_if.done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    end
    push_exp(3'd7, 32'd1001, 32'd10, 32'd1, cyc + 35);
    @(negedge clk);
    @(negedge clk);
    md_if.start = 1'b0;
    wait_done();

    // Asynchronous reset mid-CALC.
    issue(3'd4, 32'h7FFFFFFF, 32'd3, 1'b0, 32'h0);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {31'h0, md_if.busy}, 32'h0);
    check("async_rst_done", {31'h0, md_if.done}, 32'h0);
    check("async_rst_out", md_if.out, 32'h0);
    last_out = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd5, 32'd9, 32'd3, 32'd3);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  fn;
      logic [31:0] a, b;
      fn = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(fn, a, b, model(fn, a, b));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish at time %0t", $time);
    $fatal(1);
  end

endmodule
